bch_encode_serial: RTL and testbench
====================================

// Module: bch_encode_serial
// PURPOSE
//  Bit-serial systematic BCH encoder, transmit-side counterpart of the bit-serial decode pipeline.
//  Accepts K message bits MSB-first over a valid/ready stream.
//  Emits the N-bit codeword: K message bits passed through, then N-K parity bits, MSB-first.
//  Parity comes from an LFSR dividing x^(N-K)*m(x) by the generator g(x).
//  Sits between the payload source and the channel/serializer.
// PARAMETERS
//  N    15             codeword length, bits (N = 2^M - 1 or shortened)
//  K    5              message length, bits; 1 <= K < N
//  T    3              correction capability; informational, carried for consistency with decoder
//  GEN  11'b10100110111 generator polynomial g(x), N-K+1 bits, bit i = coeff of x^i; GEN[N-K] = 1
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  synchronous, active-high
//  din         in   1  message bit
//  din_valid   in   1  din is valid
//  din_ready   out  1  encoder accepts din this cycle
//  dout        out  1  codeword bit
//  dout_valid  out  1  dout is valid
//  dout_ready  in   1  sink accepts dout this cycle
//  dout_first  out  1  dout is codeword bit 0 (first message bit)
//  dout_last   out  1  dout is codeword bit N-1 (last parity bit)
//  parity      out  1  dout is a parity bit
//  abort       in   1  present only with BCH_ENC_ABORT_EN
// BEHAVIOUR
//  Reset state (clk, reset: synchronous, active-high):
//   - state = S_DATA, cnt = 0, lfsr = 0.
//   - dout, dout_valid, dout_first, dout_last, parity all 0.
//   - din_ready follows the combinational rule below (1 after reset in S_DATA).
//  Registered output stage:
//   - adv = !dout_valid || dout_ready.
//   - Stage loads when adv && (S_PARITY || (S_DATA && din_valid)).
//   - When adv and nothing loads, dout_valid <= 0.
//   - Input-to-output latency: 1 cycle. Full throughput of 1 bit/cycle with dout_ready held high.
//  Handshake:
//   - din_ready = (state == S_DATA) && adv. Combinational; does not depend on din_valid.
//   - din accepted on din_valid && din_ready.
//   - dout transferred on dout_valid && dout_ready.
//   - While !dout_ready, dout and all flags hold stable; din_ready stays 0.
//  S_DATA, one accepted bit d:
//   - fb = d ^ lfsr[N-K-1].
//   - lfsr <= (lfsr << 1) ^ ({N-K{fb}} & GEN[N-K-1:0]).
//   - dout <= d, parity <= 0, dout_first <= (cnt == 0).
//   - cnt increments. On cnt == K-1: cnt <= 0, state <= S_PARITY.
//  S_PARITY, each load:
//   - dout <= lfsr[N-K-1], lfsr <= lfsr << 1, parity <= 1.
//   - cnt increments. On cnt == N-K-1: dout_last <= 1, cnt <= 0, lfsr <= 0, state <= S_DATA.
//  Codeword boundaries:
//   - The next codeword's first bit can load in the cycle after the last parity bit loads; no bubble.
//   - cnt width is $clog2(N); it never exceeds max(K, N-K) - 1.
//   - lfsr width is N-K; it is all-zero at every codeword start.
//  Reset asserted mid-codeword:
//   - Partial codeword discarded.
//   - Outputs return to reset values on the next edge, including a pending dout_valid (the bit is dropped).
// CONFIGURATION
//  BCH_ENC_ABORT_EN defined:
//   - Adds input abort. abort=1 acts like a codeword restart: state <= S_DATA, cnt <= 0, lfsr <= 0.
//   - Unlike reset, a dout_valid already presented is held until transferred.
//   - abort has priority over a simultaneous din acceptance; that din is not consumed (din_ready forced 0).
//  BCH_ENC_ABORT_EN undefined:
//   - No abort port. Codewords end only after N bits or on reset.
// TESTING
//  1. din=0,0,0,0,0, dout_ready=1 -> dout = 15 zeros; dout_first on bit 0, dout_last on bit 14; parity high on bits 5..14.
//  2. din=0,0,0,0,1 -> dout = 00001 0100110111; lfsr = 10'b0100110111 after bit 5 accepted.
//  3. din=1,1,1,1,1 -> dout = 15 ones.
//  4. Back-to-back codewords with din_valid held 1 -> din_ready low exactly 10 cycles per codeword; no dout_valid gap.
//  5. Random dout_ready stalls (50%) over 100 random messages -> dout stream matches reference polynomial division; no bit duplicated or lost.
//  6. reset after 3 message bits, then 00001 -> clean codeword 00001 0100110111.
//     With BCH_ENC_ABORT_EN: abort during parity bit 4 -> next output starts a fresh codeword with dout_first=1.

Source files
------------

// File: rtl/bch_encode_serial.sv
// Bit-serial systematic BCH encoder: K message bits pass through, then N-K LFSR parity bits.
// Optional abort input enabled by defining BCH_ENC_ABORT_EN.
module bch_encode_serial #(
  parameter int unsigned N = 15,
  parameter int unsigned K = 5,
  parameter int unsigned T = 3,
  parameter logic [N-K:0] GEN = 11'b10100110111
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  input  logic dout_ready,
  output logic dout_first,
  output logic dout_last,
  output logic parity
`ifdef BCH_ENC_ABORT_EN
  ,
  input  logic abort
`endif
);

  localparam int unsigned PW = N - K;
  localparam int unsigned CW = $clog2(N);
  // An inconsistent parameter set leaves the encoder permanently idle.
  localparam bit CFG_OK = (K >= 1) && (K < N) && (T >= 1) && (GEN[N-K] == 1'b1);

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] lfsr;
  logic [PW-1:0] lfsr_nxt;

  logic dout_nxt;
  logic dout_valid_nxt;
  logic dout_first_nxt;
  logic dout_last_nxt;
  logic parity_nxt;

  logic adv;
  logic take;
  logic load_par;
  logic fb;
  logic abort_i;

`ifdef BCH_ENC_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Output stage may advance when empty or being drained this cycle.
  assign adv       = !dout_valid || dout_ready;
  assign din_ready = CFG_OK && (state == S_DATA) && adv && !abort_i;
  assign take      = din_valid && din_ready;
  assign load_par  = CFG_OK && (state == S_PARITY) && adv && !abort_i;
  assign fb        = din ^ lfsr[PW-1];

  // State register, counter, LFSR and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_DATA;
      cnt        <= '0;
      lfsr       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      parity     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lfsr       <= lfsr_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      dout_first <= dout_first_nxt;
      dout_last  <= dout_last_nxt;
      parity     <= parity_nxt;
    end
  end

  // Next-state: message bits feed the divider, parity bits shift it out.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    if (abort_i) begin
      state_nxt = S_DATA;
      cnt_nxt   = '0;
      lfsr_nxt  = '0;
    end else if (take) begin
      lfsr_nxt = (lfsr << 1) ^ ({PW{fb}} & GEN[PW-1:0]);
      if (cnt == CW'(K - 1)) begin
        cnt_nxt   = '0;
        state_nxt = S_PARITY;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else if (load_par) begin
      lfsr_nxt = lfsr << 1;
      if (cnt == CW'(PW - 1)) begin
        cnt_nxt   = '0;
        lfsr_nxt  = '0;
        state_nxt = S_DATA;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Output stage: hold while stalled, drop valid when advancing with nothing to load.
  always_comb begin
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;
    dout_first_nxt = dout_first;
    dout_last_nxt  = dout_last;
    parity_nxt     = parity;
    if (take) begin
      dout_nxt       = din;
      dout_valid_nxt = 1'b1;
      dout_first_nxt = (cnt == '0);
      dout_last_nxt  = 1'b0;
      parity_nxt     = 1'b0;
    end else if (load_par) begin
      dout_nxt       = lfsr[PW-1];
      dout_valid_nxt = 1'b1;
      dout_first_nxt = 1'b0;
      dout_last_nxt  = (cnt == CW'(PW - 1));
      parity_nxt     = 1'b1;
    end else if (adv) begin
      dout_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Self-checking bench for bch_encode_serial (N=15, K=5): directed codewords, back-to-back
// throughput, random output stalls against a long-division reference, and mid-codeword reset.
module tb_bch_encode_serial;

  localparam logic [10:0] GEN_TB = 11'b10100110111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic dout;
  logic dout_valid;
  logic dout_ready = 1'b1;
  logic dout_first;
  logic dout_last;
  logic parity;
`ifdef BCH_ENC_ABORT_EN
  logic abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic mon_en = 1'b0;
  logic rnd_ready = 1'b0;
  logic meas = 1'b0;
  int   n_low = 0;
  int   n_gap = 0;
  int   pos = 0;
  logic stalled = 1'b0;
  logic [4:0] held;
  logic exp_q[$];

  bch_encode_serial dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_first(dout_first),
    .dout_last(dout_last),
    .parity(parity)
`ifdef BCH_ENC_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: remainder of x^10*m(x) by plain long division.
  function automatic logic [14:0] cw_model(input logic [4:0] m);
    logic [14:0] r;
    r = {m, 10'b0};
    for (int i = 14; i >= 10; i--)
      if (r[i]) r = r ^ (15'(GEN_TB) << (i - 10));
    return {m, r[9:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
    else dout_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (meas) begin
      if (!din_ready) n_low++;
      if (!dout_valid) n_gap++;
    end
  end

  // Scoreboard: every transferred bit against the expected stream and its position flags.
  always @(negedge clk) begin
    if (!mon_en) begin
      pos = 0;
      stalled = 1'b0;
      exp_q.delete();
    end else begin
      if (stalled) check("hold_stable", {dout_valid, dout, dout_first, dout_last, parity}, held);
      stalled = dout_valid && !dout_ready;
      held = {dout_valid, dout, dout_first, dout_last, parity};
      if (stalled) check("din_ready_stall", din_ready, 1'b0);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          check("dout", dout, exp_q.pop_front());
          check("dout_first", dout_first, pos == 0);
          check("dout_last", dout_last, pos == 14);
          check("parity", parity, pos >= 5);
          pos = (pos == 14) ? 0 : pos + 1;
        end
      end
    end
  end

  task automatic push_bit(input logic b);
    int w;
    w = 0;
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!din_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [4:0] m, input logic [14:0] cw, input logic keep);
    for (int i = 0; i < 15; i++) exp_q.push_back(cw[14-i]);
    for (int i = 0; i < 5; i++) push_bit(m[4-i]);
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      w++;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] m;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_first", dout_first, 0);
    check("rst_last", dout_last, 0);
    check("rst_parity", parity, 0);
    check("rst_din_ready", din_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    send_word(5'b00000, 15'b000000000000000, 1'b0);
    drain();
    send_word(5'b00001, 15'b000010100110111, 1'b0);
    drain();
    send_word(5'b11111, 15'b111111111111111, 1'b0);
    drain();

    n_low = 0;
    n_gap = 0;
    meas = 1'b1;
    send_word(5'b10110, cw_model(5'b10110), 1'b1);
    send_word(5'b01011, cw_model(5'b01011), 1'b1);
    send_word(5'b11001, cw_model(5'b11001), 1'b1);
    meas = 1'b0;
    din_valid = 1'b0;
    check("b2b_din_ready_low", n_low, 20);
    check("b2b_dout_valid_gap", n_gap, 1);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m = 5'($urandom_range(0, 31));
      send_word(m, cw_model(m), 1'b0);
    end
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    mon_en = 1'b0;
    push_bit(1'b1);
    push_bit(1'b1);
    push_bit(1'b1);
    din_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_din_ready", din_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_word(5'b00001, 15'b000010100110111, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
